// File: rtl/imem_ws_model.sv
// Instruction-memory model: fetch handshake with WAIT programmable wait states, address-fault decode, fetch counter.
// Latency WAIT+1 cycles from req to inst_ready; requests seen during wait states are dropped, never queued.
module imem_ws_model #(
    parameter int          DEPTH = 64,
    parameter int          WAIT  = 0,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter logic [31:0] NOP   = 32'h0000_0000,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [31:0]   PC_in,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data,
    output logic [31:0]   inst_out,
    output logic          inst_ready,
    output logic          busy,
    output logic          addr_fault,
    output logic [31:0]   fetch_cnt
);

    typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;

    localparam logic [7:0] WAIT_CNT = 8'(WAIT);

    state_t        state;
    logic [7:0]    wcnt;
    logic [31:0]   pc_q;
    logic [31:0]   mem [DEPTH] = '{default: NOP};

    logic [31:0]   rd_pc;
    logic [31:0]   off;
    logic [AW-1:0] rd_idx;
    logic          rd_fault;
    logic          fin;

    // With WAIT = 0 the read happens on the accepting edge, so it decodes PC_in directly.
    always_comb begin
        rd_pc    = (state == WAITING) ? pc_q : PC_in;
        off      = rd_pc - BASE;
        rd_idx   = off[AW+1:2];
        rd_fault = (off[1:0] != 2'b00) || (off[31:AW+2] != '0);
        fin      = (state == WAITING) ? (wcnt == 8'd1) : (req && (WAIT == 0));
    end

    // Writes are never blocked by reset; contents survive it.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wcnt       <= '0;
            pc_q       <= '0;
            inst_out   <= NOP;
            inst_ready <= 1'b0;
            busy       <= 1'b0;
            addr_fault <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        pc_q <= PC_in;
                        if (WAIT == 0) begin
                            state <= DONE;
                        end else begin
                            state <= WAITING;
                            wcnt  <= WAIT_CNT;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAITING: begin
                    wcnt <= wcnt - 8'd1;
                    if (wcnt == 8'd1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Nonblocking read of mem returns the pre-write word on a same-edge collision.
            inst_ready <= fin;
            if (fin) begin
                inst_out   <= rd_fault ? NOP : mem[rd_idx];
                addr_fault <= rd_fault;
                fetch_cnt  <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_ws_model.sv
// Bench for imem_ws_model: three instances (WAIT = 0, 1, 3) against an edge-indexed reference model.
module tb_imem_ws_model;

    localparam int          NI  = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [NI];
    logic        req  [NI];
    logic        we   [NI];
    logic [31:0] pc   [NI];
    logic [31:0] wd   [NI];
    logic [5:0]  wa   [NI];
    logic [31:0] inst [NI];
    logic [31:0] cnt  [NI];
    logic        rdy  [NI];
    logic        bsy  [NI];
    logic        flt  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        imem_ws_model #(
            .DEPTH(64),
            .WAIT (g == 0 ? 0 : (g == 1 ? 1 : 3)),
            .BASE (BASE),
            .NOP  (NOP)
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .req       (req[g]),
            .PC_in     (pc[g]),
            .prog_we   (we[g]),
            .prog_addr (wa[g]),
            .prog_data (wd[g]),
            .inst_out  (inst[g]),
            .inst_ready(rdy[g]),
            .busy      (bsy[g]),
            .addr_fault(flt[g]),
            .fetch_cnt (cnt[g])
        );
    end

    logic [31:0] prog [8] = '{32'h20080005, 32'h20090001, 32'h200B0002, 32'h01095020,
                              32'h000A50C0, 32'h3C0C000A, 32'h00006820, 32'h0C000001};

    // Reference model: a fetch accepted on edge k completes on edge k + WAIT.
    logic [31:0] mm     [NI][64];
    bit          m_pend [NI];
    int          m_acc  [NI];
    logic [31:0] m_pc   [NI];
    logic [31:0] m_inst [NI];
    logic [31:0] m_cnt  [NI];
    logic        m_rdy  [NI];
    logic        m_busy [NI];
    logic        m_flt  [NI];
    int          ed;

    int vecs = 0;
    int errs = 0;

    function automatic int wait_of(int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    task automatic model_edge(int i);
        logic [31:0] off;
        if (rst[i]) begin
            m_pend[i] = 0;
            m_inst[i] = NOP;
            m_flt[i]  = 1'b0;
            m_rdy[i]  = 1'b0;
            m_cnt[i]  = 32'd0;
        end else begin
            m_rdy[i] = 1'b0;
            if (req[i] && !m_pend[i]) begin
                m_pend[i] = 1;
                m_acc[i]  = ed;
                m_pc[i]   = pc[i];
            end
            if (m_pend[i] && ed == m_acc[i] + wait_of(i)) begin
                off      = m_pc[i] - BASE;
                m_flt[i] = (off % 4 != 0) || (off / 4 >= 64);
                if (m_flt[i]) m_inst[i] = NOP;
                else          m_inst[i] = mm[i][int'(off / 4)];
                m_rdy[i]  = 1'b1;
                m_cnt[i]  = m_cnt[i] + 32'd1;
                m_pend[i] = 0;
            end
        end
        m_busy[i] = m_pend[i];
        if (we[i]) mm[i][wa[i]] = wd[i];
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_edge(i);
        ed++;
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
            pc[i] = '0; wa[i] = '0; wd[i] = '0;
        end
    endtask

    task automatic test_reset();
        idle_all();
        for (int j = 0; j < 9; j++) begin
            for (int i = 0; i < NI; i++) begin
                rst[i] = 1'b1;
                we[i]  = 1'b1;
                wa[i]  = (j < 8) ? 6'(j) : 6'd63;
                wd[i]  = (j < 8) ? prog[j] : 32'h0BAD_F00D;
            end
            step();
            if (j == 0) begin
                for (int i = 0; i < NI; i++) begin
                    vecs++;
                    if ({inst[i], rdy[i], bsy[i], flt[i], cnt[i]} !== {NOP, 3'b000, 32'd0}) begin
                        errs++;
                        $display("FAIL reset inst%0d: got inst=%h rdy=%b busy=%b flt=%b cnt=%0d, want inst=%h 0 0 0 0",
                                 i, inst[i], rdy[i], bsy[i], flt[i], cnt[i], NOP);
                    end
                end
            end
        end
        idle_all();
        step();
    endtask

    task automatic test_stream_w0();
        for (int j = 0; j < 8; j++) begin
            req[0] = 1'b1;
            pc[0]  = 32'(j * 4);
            step();
            vecs++;
            if (rdy[0] !== 1'b1 || inst[0] !== prog[j] || flt[0] !== 1'b0) begin
                errs++;
                $display("FAIL stream pc=%h: got rdy=%b inst=%h flt=%b, want 1 %h 0", pc[0], rdy[0], inst[0], flt[0], prog[j]);
            end
        end
        req[0] = 1'b0;
        vecs++;
        if (cnt[0] !== 32'd8) begin
            errs++;
            $display("FAIL stream_cnt: got %0d want 8", cnt[0]);
        end
        step();
        vecs++;
        if (rdy[0] !== 1'b0 || bsy[0] !== 1'b0 || cnt[0] !== 32'd8) begin
            errs++;
            $display("FAIL stream_end: got rdy=%b busy=%b cnt=%0d want 0 0 8", rdy[0], bsy[0], cnt[0]);
        end
    endtask

    task automatic test_wait3();
        int nb;
        int rdy_at;
        nb = 0;
        rdy_at = -1;
        for (int e = 0; e < 6; e++) begin
            req[2] = (e == 0 || e == 2);
            pc[2]  = 32'h1C;
            step();
            nb += int'(bsy[2]);
            if (rdy[2] === 1'b1 && rdy_at < 0) rdy_at = e;
        end
        req[2] = 1'b0;
        vecs++;
        if (nb != 3) begin
            errs++;
            $display("FAIL wait3_busy: got %0d busy cycles want 3", nb);
        end
        vecs++;
        if (rdy_at != 3 || inst[2] !== 32'h0C000001) begin
            errs++;
            $display("FAIL wait3_ready: got ready at edge %0d inst=%h, want edge 3 inst=0c000001", rdy_at, inst[2]);
        end
        vecs++;
        if (cnt[2] !== 32'd1) begin
            errs++;
            $display("FAIL wait3_cnt: got %0d want 1", cnt[2]);
        end
    endtask

    task automatic test_fault();
        logic [31:0] pcs [3];
        logic [31:0] exp_i [3];
        logic        exp_f [3];
        logic [31:0] c0;
        pcs   = '{32'h0E, 32'h100, 32'hFC};
        exp_i = '{NOP, NOP, 32'h0BAD_F00D};
        exp_f = '{1'b1, 1'b1, 1'b0};
        c0    = cnt[0];
        for (int k = 0; k < 3; k++) begin
            req[0] = 1'b1;
            pc[0]  = pcs[k];
            step();
            req[0] = 1'b0;
            vecs++;
            if (rdy[0] !== 1'b1 || flt[0] !== exp_f[k] || inst[0] !== exp_i[k] || cnt[0] !== c0 + 32'(k + 1)) begin
                errs++;
                $display("FAIL fault pc=%h: got rdy=%b flt=%b inst=%h cnt=%0d, want 1 %b %h %0d",
                         pcs[k], rdy[0], flt[0], inst[0], cnt[0], exp_f[k], exp_i[k], c0 + 32'(k + 1));
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        req[2] = 1'b1; pc[2] = 32'h10;
        step();
        req[2] = 1'b0;
        step();
        rst[2] = 1'b1;
        step();
        rst[2] = 1'b0;
        vecs++;
        if ({inst[2], rdy[2], bsy[2], flt[2], cnt[2]} !== {NOP, 3'b000, 32'd0}) begin
            errs++;
            $display("FAIL reset_mid: got inst=%h rdy=%b busy=%b flt=%b cnt=%0d, want %h 0 0 0 0",
                     inst[2], rdy[2], bsy[2], flt[2], cnt[2], NOP);
        end
        step();
        vecs++;
        if (rdy[2] !== 1'b0 || cnt[2] !== 32'd0) begin
            errs++;
            $display("FAIL reset_abort: got rdy=%b cnt=%0d want 0 0", rdy[2], cnt[2]);
        end
        req[2] = 1'b1; pc[2] = 32'h0C;
        step();
        req[2] = 1'b0;
        seen = 0;
        for (int e = 0; e < 8 && !seen; e++) begin
            step();
            if (rdy[2] === 1'b1) seen = 1;
        end
        vecs++;
        if (!seen || inst[2] !== 32'h01095020 || cnt[2] !== 32'd1) begin
            errs++;
            $display("FAIL reset_refetch: got seen=%0d inst=%h cnt=%0d, want 1 01095020 1", seen, inst[2], cnt[2]);
        end
        step();
    endtask

    task automatic test_collision();
        req[1] = 1'b1; pc[1] = 32'h0C;
        step();
        req[1] = 1'b0;
        we[1] = 1'b1; wa[1] = 6'd3; wd[1] = 32'hDEAD_BEEF;
        step();
        we[1] = 1'b0;
        vecs++;
        if (rdy[1] !== 1'b1 || inst[1] !== 32'h01095020) begin
            errs++;
            $display("FAIL collision_old: got rdy=%b inst=%h want 1 01095020", rdy[1], inst[1]);
        end
        req[1] = 1'b1; pc[1] = 32'h0C;
        step();
        req[1] = 1'b0;
        step();
        vecs++;
        if (rdy[1] !== 1'b1 || inst[1] !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL collision_new: got rdy=%b inst=%h want 1 deadbeef", rdy[1], inst[1]);
        end
        step();
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NI; i++) begin
                rst[i] = ($urandom_range(0, 49) == 0);
                req[i] = ($urandom_range(0, 2) != 0);
                pc[i]  = ($urandom_range(0, 9) == 0) ? $urandom : (32'($urandom_range(0, 70)) << 2);
                we[i]  = ($urandom_range(0, 3) == 0);
                wa[i]  = 6'($urandom_range(0, 63));
                wd[i]  = $urandom;
            end
            step();
            for (int i = 0; i < NI; i++) begin
                vecs++;
                if ({inst[i], rdy[i], bsy[i], flt[i], cnt[i]} !==
                    {m_inst[i], m_rdy[i], m_busy[i], m_flt[i], m_cnt[i]}) begin
                    errs++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL random inst%0d edge %0d: got inst=%h rdy=%b busy=%b flt=%b cnt=%0d, want %h %b %b %b %0d",
                                 i, ed, inst[i], rdy[i], bsy[i], flt[i], cnt[i],
                                 m_inst[i], m_rdy[i], m_busy[i], m_flt[i], m_cnt[i]);
                    end
                end
            end
        end
        idle_all();
        for (int e = 0; e < 6; e++) step();
    endtask

    initial begin
        ed = 0;
        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < 64; w++) mm[i][w] = NOP;
            m_pend[i] = 0; m_acc[i] = 0; m_pc[i] = '0; m_inst[i] = NOP;
            m_cnt[i] = '0; m_rdy[i] = 1'b0; m_busy[i] = 1'b0; m_flt[i] = 1'b0;
        end
        idle_all();
        #2;
        test_reset();
        test_stream_w0();
        test_wait3();
        test_fault();
        test_reset_mid();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
